// File: rtl/deser_pkg.sv
// deser_pkg: shared definitions for the serial deserializer.
//   DefaultWidth   - default assembled word width
//   deser_state_e  - receive FSM state encoding
package deser_pkg;

    localparam int unsigned DefaultWidth = 4;

    // StIdle = IDLE, StRecv = RECV, StParity = PARITY
    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StRecv   = 2'b01,
        StParity = 2'b10
    } deser_state_e;

endpackage

// File: rtl/deser_shift_stage.sv
// deser_shift_stage: WIDTH-bit bidirectional shift register holding the word under assembly.
//   clk_i        - rising-edge clock
//   rst_i        - asynchronous active-high reset, clears the register
//   en_i         - shift one bit in on this edge
//   dir_i        - 0: shift left (bit enters LSB), 1: shift right (bit enters MSB)
//   bit_i        - incoming serial bit
//   shreg_next_o - value the register takes on the next edge (equals the register when en_i is low)
module deser_shift_stage #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             dir_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] shreg_next_o
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (en_i) begin
            if (dir_i) begin
                shreg_d = {bit_i, shreg_q[WIDTH-1:1]};
            end else begin
                shreg_d = {shreg_q[WIDTH-2:0], bit_i};
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign shreg_next_o = shreg_d;

endmodule

// File: rtl/serial_deserializer.sv
// serial_deserializer: assembles WIDTH serial bits into a word and hands it to a
// valid/ready consumer through a one-entry output buffer.
//   clock        - rising-edge clock
//   reset        - asynchronous active-high reset
//   serial_in    - serial data bit, sampled when bit_valid is high
//   bit_valid    - serial_in carries a bit on this edge
//   dir          - 0 MSB-first, 1 LSB-first; latched with the first bit of a word
//   data_out     - assembled word
//   out_valid    - data_out holds an unconsumed word
//   out_ready    - consumer takes data_out when out_valid && out_ready
//   overrun      - one-cycle pulse: a completed word was dropped
//   parity_error - (SERIAL_DESERIALIZER_PARITY_EN only) even-parity check failed for data_out
// Build option: define SERIAL_DESERIALIZER_PARITY_EN to expect a trailing even-parity bit
// after the WIDTH data bits.
module serial_deserializer
    import deser_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             serial_in,
    input  logic             bit_valid,
    input  logic             dir,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun
`ifdef SERIAL_DESERIALIZER_PARITY_EN
    ,
    output logic             parity_error
`endif
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    deser_state_e     state_q;
    logic [CntW-1:0]  count_q;
    logic             dir_q;

    logic             shift_en;
    logic             shift_dir;
    logic             last_data;
    logic             word_done;
    logic [WIDTH-1:0] shreg_next;

    // Data bits are only taken outside the parity slot.
    assign shift_en  = bit_valid && (state_q == StIdle || state_q == StRecv);
    // The first bit uses dir directly since dir_q is only captured on that same edge.
    assign shift_dir = (state_q == StIdle) ? dir : dir_q;
    assign last_data = shift_en && (count_q == CntW'(WIDTH - 1));

`ifdef SERIAL_DESERIALIZER_PARITY_EN
    logic parity_bad;
    assign word_done  = bit_valid && (state_q == StParity);
    // Shift is disabled in the parity slot, so shreg_next is the finished data word.
    assign parity_bad = (^shreg_next) ^ serial_in;
`else
    assign word_done  = last_data;
`endif

    deser_shift_stage #(
        .WIDTH (WIDTH)
    ) u_shift_stage (
        .clk_i        (clock),
        .rst_i        (reset),
        .en_i         (shift_en),
        .dir_i        (shift_dir),
        .bit_i        (serial_in),
        .shreg_next_o (shreg_next)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            count_q      <= '0;
            dir_q        <= 1'b0;
            data_out     <= '0;
            out_valid    <= 1'b0;
            overrun      <= 1'b0;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
            parity_error <= 1'b0;
`endif
        end else begin
            overrun <= 1'b0;

            case (state_q)
                StIdle, StRecv: begin
                    if (bit_valid) begin
                        if (state_q == StIdle) begin
                            dir_q <= dir;
                        end
                        if (last_data) begin
                            count_q <= '0;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
                            state_q <= StParity;
`else
                            state_q <= StIdle;
`endif
                        end else begin
                            count_q <= count_q + CntW'(1);
                            state_q <= StRecv;
                        end
                    end
                end
`ifdef SERIAL_DESERIALIZER_PARITY_EN
                StParity: begin
                    if (bit_valid) begin
                        state_q <= StIdle;
                    end
                end
`endif
                default: begin
                    state_q <= StIdle;
                    count_q <= '0;
                end
            endcase

            // Output buffer: a completing word wins over an unaccepted one only if the
            // buffer is free or being drained on this same edge.
            if (word_done) begin
                if (out_valid && !out_ready) begin
                    overrun <= 1'b1;
                end else begin
                    data_out     <= shreg_next;
                    out_valid    <= 1'b1;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
                    parity_error <= parity_bad;
`endif
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/serial_deserializer.md
SERIAL_DESERIALIZER -- requirements
Module: serial_deserializer

Interface
REQ-001 SHALL use one clock and an asynchronous, active-high reset; ports named clock and reset.
REQ-002 SHALL have parameter WIDTH, default 4, giving the assembled word width (legal range 2..16).
REQ-003 SHALL have port: clock  input  1  rising-edge clock for all state.
REQ-004 SHALL have port: reset  input  1  asynchronous active-high reset.
REQ-005 SHALL have port: serial_in  input  1  serial data bit.
REQ-006 SHALL have port: bit_valid  input  1  serial_in is sampled on this edge.
REQ-007 SHALL have port: dir  input  1  0 = MSB-first (shift left), 1 = LSB-first (shift right); latched at first bit of each word.
REQ-008 SHALL have port: data_out  output  WIDTH  assembled word.
REQ-009 SHALL have port: out_valid  output  1  data_out holds an unconsumed word.
REQ-010 SHALL have port: out_ready  input  1  consumer accepts data_out when out_valid && out_ready.
REQ-011 SHALL have port: overrun  output  1  one-cycle pulse; completed word dropped.

Function
REQ-012 SHALL implement states IDLE, RECV and, with parity enabled, PARITY.
REQ-013 IDLE: on bit_valid, latch dir, shift in first bit, count=1, go to RECV (go directly to word completion when WIDTH reached).
REQ-014 RECV: on each bit_valid shift in one bit; dir=0: shreg <= {shreg[WIDTH-2:0], serial_in}; dir=1: shreg <= {serial_in, shreg[WIDTH-1:1]}.
REQ-015 Cycles without bit_valid SHALL hold state, count and shreg unchanged.
REQ-016 On the edge sampling bit WIDTH (or the parity bit), word completes; data_out/out_valid update on that edge (visible next cycle); state returns to IDLE, count=0.
REQ-017 Changes on dir after the first bit of a word SHALL be ignored until the next word.
REQ-018 Output holding register is separate from shreg; reception of the next word continues while out_valid is high.
REQ-019 out_valid SHALL clear on the edge where out_valid && out_ready and no word completes.
REQ-020 Completion while out_valid && !out_ready: data_out retained, new word dropped, overrun=1 for one cycle.
REQ-021 Completion in the same cycle as acceptance: new word loaded, out_valid stays 1, no overrun.
REQ-022 data_out SHALL NOT change while out_valid=1 except per REQ-021.

Reset
REQ-023 Reset SHALL force state=IDLE, count=0, shreg=0, data_out=0, out_valid=0, overrun=0, independent of clock.
REQ-024 Reset mid-word SHALL discard the partial word; first bit_valid after release starts a new word.

Configuration
REQ-025 Macro SERIAL_DESERIALIZER_PARITY_EN, when defined, SHALL add a trailing even-parity bit after WIDTH data bits (PARITY state) and output port parity_error (1 bit, reset 0).
REQ-026 With the macro defined, parity_error SHALL be registered alongside the word on completion and held with data_out; the word is delivered regardless.
REQ-027 Without the macro: no PARITY state, no parity_error port, word completes on data bit WIDTH.

Structure
REQ-028 State encoding (IDLE=2'b00, RECV=2'b01, PARITY=2'b10) and default WIDTH constant SHALL reside in shared package deser_pkg.
REQ-029 Sub-module deser_shift_stage (WIDTH-bit bidirectional shift register with enable and direction) SHALL hold shreg; FSM, counter and output buffer stay in the top module.

Verification
REQ-030 WIDTH=4, dir=0, bits 1,0,1,1 on consecutive cycles, out_ready=1 -> data_out=4'b1011, out_valid high exactly one cycle.
REQ-031 dir=1, bits 1,0,1,1 -> data_out=4'b1101; dir toggled to 0 after bit 1 -> result unchanged.
REQ-032 out_ready=0, send 4'hA then 4'h5 -> data_out stays 4'hA, overrun pulses once on 4'h5 completion; raise out_ready -> out_valid drops.
REQ-033 Word 4'h3 completes on the same edge 4'hC is accepted -> data_out=4'h3, out_valid stays 1, overrun=0.
REQ-034 Reset asserted after 2 bits, released, then 4 bits 0,1,1,0 (dir=0) -> data_out=4'h6; outputs 0 during reset.
REQ-035 With SERIAL_DESERIALIZER_PARITY_EN: bits 1,0,1,1 + parity 1 -> data_out=4'hB, parity_error=0; parity 0 -> parity_error=1.
